// File: rtl/pipe_stall_ctrl.sv
// Pipeline sequencer for the 5-stage core: merges stall requests, runs the divider
// handshake, turns exceptions into flush + redirect and counts stall cycles.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | normal flow; a div request issues a start pulse
// DIV_WAIT | divider busy, ex stage stalled, wait counter running
// DIV_HOLD | result valid for one cycle, ex-stall released
module pipe_stall_ctrl #(
    parameter int DIV_TIMEOUT = 64,
    parameter int PC_WIDTH    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pause_if_i,
    input  logic                pause_id_i,
    input  logic                pause_mem_i,
    input  logic                div_req_i,
    input  logic                div_done_i,
    input  logic                exc_i,
    input  logic [PC_WIDTH-1:0] exc_pc_i,
    output logic [5:0]          pause_o,
    output logic                flush_o,
    output logic [PC_WIDTH-1:0] new_pc_o,
    output logic                div_start_o,
    output logic                div_cancel_o,
    output logic                div_ready_o,
    output logic                div_timeout_o,
    output logic [31:0]         stall_cnt_o
);
    localparam int CW = $clog2(DIV_TIMEOUT + 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DIV_WAIT = 2'd1,
        DIV_HOLD = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_wait_cnt;
    logic [CW-1:0] w_wait_cnt_nxt;
    logic          r_timeout;
    logic [31:0]   r_stall_cnt;
    logic          w_ex_stall;
    logic          w_start;
    logic          w_cancel;
    logic          w_ready;
    logic [5:0]    w_pause;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= RUN;
            r_wait_cnt  <= '0;
            r_timeout   <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            if (r_state == DIV_WAIT && w_wait_cnt_nxt == CW'(DIV_TIMEOUT))
                r_timeout <= 1'b1;
            if (pause_o != 6'd0)
                r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_ex_stall     = 1'b0;
        w_start        = 1'b0;
        w_cancel       = 1'b0;
        w_ready        = 1'b0;
        case (r_state)
            RUN: begin
                w_ex_stall = div_req_i;
                if (div_req_i && !exc_i) begin
                    w_start        = 1'b1;
                    w_state_nxt    = DIV_WAIT;
                    w_wait_cnt_nxt = '0;
                end
            end
            DIV_WAIT: begin
                w_ex_stall = 1'b1;
                if (r_wait_cnt != CW'(DIV_TIMEOUT))
                    w_wait_cnt_nxt = r_wait_cnt + 1'b1;
                // an exception wins over a result arriving in the same cycle
                if (exc_i) begin
                    w_cancel    = 1'b1;
                    w_state_nxt = RUN;
                end else if (div_done_i) begin
                    w_state_nxt = DIV_HOLD;
                end
            end
            DIV_HOLD: begin
                w_state_nxt = RUN;
                if (exc_i) w_cancel = 1'b1;
                else       w_ready  = 1'b1;
            end
            default: w_state_nxt = RUN;
        endcase
    end

    always_comb begin
        w_pause = 6'b000000;
        if (exc_i)            w_pause = 6'b000000;
        else if (pause_mem_i) w_pause = 6'b011111;
        else if (w_ex_stall)  w_pause = 6'b001111;
        else if (pause_id_i)  w_pause = 6'b000111;
        else if (pause_if_i)  w_pause = 6'b000011;
    end

    // combinational outputs are held at zero while reset is asserted
    assign pause_o       = rst ? w_pause : 6'd0;
    assign flush_o       = rst & exc_i;
    assign new_pc_o      = flush_o ? exc_pc_i : '0;
    assign div_start_o   = rst & w_start;
    assign div_cancel_o  = rst & w_cancel;
    assign div_ready_o   = rst & w_ready;
    assign div_timeout_o = r_timeout;
    assign stall_cnt_o   = r_stall_cnt;
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_pipe_stall_ctrl;
    localparam int T  = 8;
    localparam int PW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          pause_if_i = 1'b0, pause_id_i = 1'b0, pause_mem_i = 1'b0;
    logic          div_req_i = 1'b0, div_done_i = 1'b0, exc_i = 1'b0;
    logic [PW-1:0] exc_pc_i = '0;
    logic [5:0]    pause_o;
    logic          flush_o, div_start_o, div_cancel_o, div_ready_o, div_timeout_o;
    logic [PW-1:0] new_pc_o;
    logic [31:0]   stall_cnt_o;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    pipe_stall_ctrl #(.DIV_TIMEOUT(T), .PC_WIDTH(PW)) dut (
        .clk(clk), .rst(rst),
        .pause_if_i(pause_if_i), .pause_id_i(pause_id_i), .pause_mem_i(pause_mem_i),
        .div_req_i(div_req_i), .div_done_i(div_done_i),
        .exc_i(exc_i), .exc_pc_i(exc_pc_i),
        .pause_o(pause_o), .flush_o(flush_o), .new_pc_o(new_pc_o),
        .div_start_o(div_start_o), .div_cancel_o(div_cancel_o),
        .div_ready_o(div_ready_o), .div_timeout_o(div_timeout_o),
        .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk = ~clk;

    // Model: is a divide outstanding, is a result being handed over, how long we have waited.
    bit          m_busy = 1'b0;
    bit          m_hold = 1'b0;
    bit          m_to   = 1'b0;
    int          m_wc   = 0;
    logic [31:0] m_cnt  = '0;

    logic [5:0]    e_pause;
    logic          e_start, e_cancel, e_ready, e_flush, e_ex;
    logic [PW-1:0] e_pc;

    always_comb begin
        e_ex     = m_busy || (!m_hold && div_req_i);
        e_pause  = 6'h00;
        if (!rst || exc_i)  e_pause = 6'h00;
        else if (pause_mem_i) e_pause = 6'h1F;
        else if (e_ex)        e_pause = 6'h0F;
        else if (pause_id_i)  e_pause = 6'h07;
        else if (pause_if_i)  e_pause = 6'h03;
        e_flush  = rst && exc_i;
        e_pc     = e_flush ? exc_pc_i : '0;
        e_start  = rst && !m_busy && !m_hold && div_req_i && !exc_i;
        e_cancel = rst && exc_i && (m_busy || m_hold);
        e_ready  = rst && m_hold && !exc_i;
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy = 1'b0; m_hold = 1'b0; m_to = 1'b0; m_wc = 0; m_cnt = '0;
        end else begin
            if (e_pause != 6'h00) m_cnt = m_cnt + 32'd1;
            if (m_busy) begin
                m_wc = (m_wc < T) ? m_wc + 1 : T;
                if (m_wc >= T) m_to = 1'b1;
                if (exc_i) m_busy = 1'b0;
                else if (div_done_i) begin m_busy = 1'b0; m_hold = 1'b1; end
            end else if (m_hold) begin
                m_hold = 1'b0;
            end else if (div_req_i && !exc_i) begin
                m_busy = 1'b1; m_wc = 0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_pause",   32'(pause_o),       32'(e_pause));
            chk("m_flush",   32'(flush_o),       32'(e_flush));
            chk("m_new_pc",  new_pc_o,           e_pc);
            chk("m_start",   32'(div_start_o),   32'(e_start));
            chk("m_cancel",  32'(div_cancel_o),  32'(e_cancel));
            chk("m_ready",   32'(div_ready_o),   32'(e_ready));
            chk("m_timeout", 32'(div_timeout_o), 32'(m_to));
            chk("m_stall",   stall_cnt_o,        m_cnt);
        end
    end

    task automatic mid(); @(negedge clk); #1; endtask
    task automatic nxt(); @(posedge clk); #1; endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        chk_en = 1'b1;

        mid();
        chk("rst_cnt", stall_cnt_o, 32'd0);
        chk("rst_to", 32'(div_timeout_o), 32'd0);
        chk("rst_pause", 32'(pause_o), 32'h00);
        nxt();

        pause_id_i = 1'b1;
        mid(); chk("id_c0", 32'(pause_o), 32'h07); nxt();
        mid(); chk("id_c1", 32'(pause_o), 32'h07); nxt();
        pause_id_i = 1'b0;
        mid(); chk("id_after", 32'(pause_o), 32'h00); chk("id_cnt", stall_cnt_o, 32'd2); nxt();

        div_req_i = 1'b1;
        mid(); chk("div_start", 32'(div_start_o), 32'd1); chk("div_p0", 32'(pause_o), 32'h0F); nxt();
        for (int i = 1; i < 5; i++) begin
            mid(); chk("div_wait_p", 32'(pause_o), 32'h0F); chk("div_nostart", 32'(div_start_o), 32'd0); nxt();
        end
        div_done_i = 1'b1;
        mid(); chk("div_done_p", 32'(pause_o), 32'h0F); nxt();
        div_done_i = 1'b0; div_req_i = 1'b0;
        mid(); chk("div_ready", 32'(div_ready_o), 32'd1); chk("div_hold_p", 32'(pause_o), 32'h00); nxt();
        mid(); chk("div_run_rdy", 32'(div_ready_o), 32'd0); chk("div_run_st", 32'(div_start_o), 32'd0); nxt();
        mid(); chk("div_cnt", stall_cnt_o, 32'd8); nxt();

        div_req_i = 1'b1;
        mid(); nxt();
        pause_mem_i = 1'b1; pause_id_i = 1'b1;
        mid(); chk("mem_id_wait", 32'(pause_o), 32'h1F); nxt();
        pause_mem_i = 1'b0; pause_id_i = 1'b0;

        exc_i = 1'b1; exc_pc_i = 32'h1C000000;
        mid();
        chk("exc_flush", 32'(flush_o), 32'd1);
        chk("exc_pc", new_pc_o, 32'h1C000000);
        chk("exc_cancel", 32'(div_cancel_o), 32'd1);
        chk("exc_pause", 32'(pause_o), 32'h00);
        chk("exc_nostart", 32'(div_start_o), 32'd0);
        nxt();
        exc_i = 1'b0; exc_pc_i = '0; div_req_i = 1'b0;
        mid(); chk("exc_rdy0", 32'(div_ready_o), 32'd0); chk("exc_pc0", new_pc_o, 32'd0); nxt();
        mid(); chk("exc_rdy1", 32'(div_ready_o), 32'd0); chk("exc_run_p", 32'(pause_o), 32'h00); nxt();

        div_req_i = 1'b1;
        mid(); nxt();
        for (int i = 0; i < T; i++) begin
            mid(); chk("to_early", 32'(div_timeout_o), 32'd0); nxt();
        end
        mid(); chk("to_set", 32'(div_timeout_o), 32'd1);
        div_done_i = 1'b1;
        nxt();
        div_done_i = 1'b0; div_req_i = 1'b0;
        mid(); chk("to_hold_rdy", 32'(div_ready_o), 32'd1); chk("to_sticky0", 32'(div_timeout_o), 32'd1); nxt();
        mid(); chk("to_sticky1", 32'(div_timeout_o), 32'd1); nxt();

        div_req_i = 1'b1; pause_if_i = 1'b1;
        mid(); nxt();
        mid(); nxt();
        #2 rst = 1'b0;
        #1;
        chk("ar_pause", 32'(pause_o), 32'h00);
        chk("ar_cnt", stall_cnt_o, 32'd0);
        chk("ar_to", 32'(div_timeout_o), 32'd0);
        chk("ar_start", 32'(div_start_o), 32'd0);
        chk("ar_ready", 32'(div_ready_o), 32'd0);
        chk("ar_cancel", 32'(div_cancel_o), 32'd0);
        chk("ar_flush", 32'(flush_o), 32'd0);
        mid();
        rst = 1'b1; div_req_i = 1'b0; pause_if_i = 1'b0;
        nxt();
        mid();
        chk("rel_cnt", stall_cnt_o, 32'd0);
        chk("rel_pause", 32'(pause_o), 32'h00);
        div_req_i = 1'b1;
        #1;
        chk("rel_start", 32'(div_start_o), 32'd1);
        chk("rel_pause_ex", 32'(pause_o), 32'h0F);
        nxt();

        for (int i = 0; i < 3000; i++) begin
            pause_if_i  = ($urandom_range(0, 3) == 0);
            pause_id_i  = ($urandom_range(0, 3) == 0);
            pause_mem_i = ($urandom_range(0, 5) == 0);
            div_req_i   = ($urandom_range(0, 2) != 0);
            div_done_i  = ($urandom_range(0, 5) == 0);
            exc_i       = ($urandom_range(0, 15) == 0);
            exc_pc_i    = $urandom();
            rst         = ($urandom_range(0, 299) != 0);
            nxt();
        end
        rst = 1'b1;
        nxt();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
Central pipeline sequencer for the 5-stage LoongArch core (pc/if_id/id_ex/ex_mem/mem_wb). It merges per-stage stall requests into the 6-bit pause vector and owns the multi-cycle divider handshake through an FSM. It also converts exceptions into a pipeline flush with a redirect PC, and counts stall cycles for performance monitoring.

Parameters:
DIV_TIMEOUT, 64, cycles allowed in DIV_WAIT before div_timeout_o is set
PC_WIDTH, 32, width of exc_pc_i / new_pc_o

Ports:
clk  in  1  core clock
rst  in  1  reset; asynchronous, active-low
pause_if_i  in  1  fetch not ready
pause_id_i  in  1  load-use hazard in decode
pause_mem_i  in  1  data memory not ready
div_req_i  in  1  ex holds a div/mod op, level
div_done_i  in  1  divider result valid, 1-cycle pulse
exc_i  in  1  exception committed in mem stage
exc_pc_i  in  PC_WIDTH  exception entry address
pause_o  out  6  bit0 pc, 1 if_id, 2 id_ex, 3 ex_mem, 4 mem_wb, 5 reserved (always 0)
flush_o  out  1  clear all pipeline registers this edge
new_pc_o  out  PC_WIDTH  redirect target, valid when flush_o=1
div_start_o  out  1  start pulse to divider
div_cancel_o  out  1  abort pulse to divider
div_ready_o  out  1  ex may consume divider result this cycle
div_timeout_o  out  1  sticky divider-timeout flag
stall_cnt_o  out  32  cycles with pause_o != 0

Behaviour:
- Reset (rst=0, asynchronous): state=RUN, wait counter=0, stall_cnt_o=0, div_timeout_o=0. All other outputs read 0 while in reset.
- FSM states: RUN, DIV_WAIT, DIV_HOLD.
- RUN:
  - div_req_i=1 and exc_i=0: div_start_o=1 for this cycle only; next state DIV_WAIT; wait counter cleared.
- DIV_WAIT:
  - Internal ex-stall is asserted; wait counter increments per cycle, saturating at DIV_TIMEOUT.
  - div_done_i=1: next state DIV_HOLD.
  - Counter reaches DIV_TIMEOUT: div_timeout_o set (sticky until reset); state unchanged.
- DIV_HOLD:
  - div_ready_o=1 and the ex-stall is released for exactly one cycle; next state RUN.
  - If div_req_i is still 1 in the following RUN cycle, a new divide is started (back-to-back ops).
- Stall request for this cycle = (pause_mem_i, ex-stall, pause_id_i, pause_if_i). pause_o is combinational in the same cycle; highest-priority active request wins:
  - mem stall: 6'b011111
  - ex stall (DIV_WAIT, or RUN with div_req_i=1): 6'b001111
  - id stall: 6'b000111
  - if stall: 6'b000011
  - none: 6'b000000
- Exception (exc_i=1): flush_o=1 and new_pc_o=exc_pc_i combinationally; pause_o is forced to 0; div_start_o is suppressed.
  - In DIV_WAIT or DIV_HOLD, div_cancel_o=1 for that cycle and next state is RUN.
  - exc_i has priority over div_done_i in the same cycle.
- When flush_o=0, new_pc_o=0.
- pause_mem_i during DIV_HOLD: div_ready_o stays high and the FSM still returns to RUN. The ex_mem stage is paused, so ex holds the result in its own output register.
- stall_cnt_o increments by 1 at each edge where pause_o != 0 and wraps at 2^32 without a flag. It does not count in flush cycles.

Test Plan:
- Only pause_id_i=1 for 2 cycles -> pause_o=6'h07 for both cycles, stall_cnt_o=2, then pause_o=0.
- div_req_i=1 from RUN; div_done_i pulses 5 cycles later -> div_start_o 1 cycle; pause_o=6'h0F for 6 cycles; div_ready_o for 1 cycle with pause_o=0; state back to RUN.
- pause_mem_i=1 and pause_id_i=1 in the same cycle during DIV_WAIT -> pause_o=6'h1F.
- exc_i=1, exc_pc_i=0x1C000000 during DIV_WAIT -> flush_o=1, new_pc_o=0x1C000000, div_cancel_o=1, pause_o=0; next cycle RUN, div_ready_o never asserts.
- DIV_TIMEOUT=8, div_done_i never arrives -> div_timeout_o rises after 8 DIV_WAIT cycles and stays high after a later div_done_i.
- rst driven low mid-DIV_WAIT, asynchronous to clk -> all outputs 0 immediately; after release, state RUN and stall_cnt_o=0.
